mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage. The pipeline stalls on each side until that side's `ready` pulses. The arbiter grants one access at a time and sequences the fixed-latency memory. It returns read data to the winning requester and discards fetches squashed by a taken branch or jump. It sits between the IF/MEM stage logic (driven by `wmem`/`m2reg` decode) and the memory macro.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/arb_lat_cnt.sv | 33 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   state_t     : arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   owner_t     : which pipeline side owns the current access
//   MEM_LAT_MIN : smallest legal memory latency
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_LAT_MIN = 1;

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter that times the fixed memory latency.
//   clock : rising-edge clock
//   reset : synchronous active-high, clears the count
//   load  : load MEM_LAT-1
//   dec   : decrement by one (ignored when load is high)
//   zero  : count is zero
module arb_lat_cnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF)
// and data memory (DM) and sequences each fixed-latency access:
// IDLE -> ISSUE (mem_en) -> WAIT (MEM_LAT cycles) -> DONE (ready pulse).
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise data
// has fixed priority over fetch.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   if_req/if_addr/if_flush   : fetch request, PC, squash (taken branch/jump)
//   if_rdata/if_ready         : fetched instruction and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : load/store request
//   dm_rdata/dm_ready         : load data and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory macro interface
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (MEM_LAT < MEM_LAT_MIN) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  state_t        state, state_next;
  owner_t        owner, pick;
  logic          grant;
  logic          if_ok;
  logic          squash;
  logic          cnt_zero;
  logic          if_done_ok;
  logic          dm_done;
  logic [DW-1:0] rdata_stage;
  logic [DW-1:0] if_held;
  logic [DW-1:0] dm_held;

  // A fetch raised together with its own flush is already dead.
  assign if_ok = if_req && !if_flush;
  assign grant = dm_req || if_ok;

`ifdef ARB_RR_EN
  owner_t last;

  always_comb begin
    pick = OWN_IF;
    if (dm_req && if_ok) begin
      pick = (last == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (dm_req) begin
      pick = OWN_DM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= OWN_IF;
    end else if (state == IDLE && grant) begin
      last <= pick;
    end
  end
`else
  always_comb begin
    pick = dm_req ? OWN_DM : OWN_IF;
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  arb_lat_cnt #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_cnt (
    .clock(clock),
    .reset(reset),
    .load (state == ISSUE),
    .dec  (state == WAIT && !cnt_zero),
    .zero (cnt_zero)
  );

  // Read data lands in a shared stage register; the per-side held copies are
  // only updated at a non-squashed completion, so a flush arriving even in
  // the DONE cycle leaves if_rdata untouched.
  assign if_done_ok = (state == DONE) && (owner == OWN_IF) && !squash && !if_flush;
  assign dm_done    = (state == DONE) && (owner == OWN_DM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      squash      <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      rdata_stage <= '0;
      if_held     <= '0;
      dm_held     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        squash <= 1'b0;
        if (grant) begin
          owner     <= pick;
          mem_addr  <= (pick == OWN_DM) ? dm_addr : if_addr;
          mem_we    <= (pick == OWN_DM) && dm_we;
          mem_wdata <= (pick == OWN_DM) ? dm_wdata : '0;
        end
      end else if (owner == OWN_IF && if_flush) begin
        squash <= 1'b1;
      end
      if (state == WAIT && cnt_zero) begin
        rdata_stage <= mem_rdata;
      end
      if (if_done_ok) begin
        if_held <= rdata_stage;
      end
      if (dm_done && !mem_we) begin
        dm_held <= rdata_stage;
      end
    end
  end

  assign mem_en   = (state == ISSUE);
  assign if_ready = if_done_ok;
  assign if_rdata = if_done_ok ? rdata_stage : if_held;
  assign dm_ready = dm_done;
  assign dm_rdata = (dm_done && !mem_we) ? rdata_stage : dm_held;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mips_pkg::*;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, mem_en, mem_we;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;
  logic [31:0] pipe1 = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2001_0005;
      32'h0000_0100: return 32'h8C00_1234;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Two-cycle memory: data appears LAT cycles after mem_en, junk otherwise.
  always @(posedge clock) begin
    pipe1     <= mem_en ? memval(mem_addr) : 32'hBAD0_BAD0;
    mem_rdata <= pipe1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    total_cnt++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %b want 0", mem_en); else pass_cnt++;
    total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) $display("FAIL reset_ready got %b%b want 00", if_ready, dm_ready); else pass_cnt++;
    total_cnt++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, dm_rdata); else pass_cnt++;
    total_cnt++; if (dut.state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dut.state); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total_cnt++; if (mem_en !== (c == 1)) $display("FAIL fetch_mem_en c%0d got %b want %b", c, mem_en, c == 1); else pass_cnt++;
      total_cnt++; if (if_ready !== (c == 4)) $display("FAIL fetch_if_ready c%0d got %b want %b", c, if_ready, c == 4); else pass_cnt++;
      if (c == 1) begin
        total_cnt++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) $display("FAIL fetch_issue got %h/%b want 00000040/0", mem_addr, mem_we); else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++; if (if_rdata !== 32'h2001_0005) $display("FAIL fetch_rdata got %h want 20010005", if_rdata); else pass_cnt++;
        last_if = 32'h2001_0005;
        if_req = 1'b0;
      end
      if (c == 5) begin
        total_cnt++; if (dut.state !== IDLE) $display("FAIL fetch_idle got %0d want IDLE", dut.state); else pass_cnt++;
      end
    end
  endtask

  task automatic test_priority;
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      total_cnt++; if (mem_en !== (c == 1 || c == 6)) $display("FAIL prio_mem_en c%0d got %b", c, mem_en); else pass_cnt++;
      total_cnt++; if (dm_ready !== (c == 4)) $display("FAIL prio_dm_ready c%0d got %b want %b", c, dm_ready, c == 4); else pass_cnt++;
      total_cnt++; if (if_ready !== (c == 9)) $display("FAIL prio_if_ready c%0d got %b want %b", c, if_ready, c == 9); else pass_cnt++;
      if (c == 1) begin
        total_cnt++; if (mem_addr !== 32'h100) $display("FAIL prio_dm_addr got %h want 00000100", mem_addr); else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++; if (dm_rdata !== 32'h8C00_1234) $display("FAIL prio_dm_rdata got %h want 8c001234", dm_rdata); else pass_cnt++;
        last_dm = 32'h8C00_1234;
        dm_req = 1'b0;
      end
      if (c == 6) begin
        total_cnt++; if (mem_addr !== 32'h44) $display("FAIL prio_if_addr got %h want 00000044", mem_addr); else pass_cnt++;
      end
      if (c == 9) begin
        total_cnt++; if (if_rdata !== memval(32'h44)) $display("FAIL prio_if_rdata got %h want %h", if_rdata, memval(32'h44)); else pass_cnt++;
        last_if = memval(32'h44);
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_arb_windows;
    logic [2:0] want;
`ifdef ARB_RR_EN
    want = 3'b101;  // window 0: DM, 1: IF, 2: DM
`else
    want = 3'b111;
`endif
    for (int w = 0; w < 3; w++) begin
      logic won_dm;
      logic seen;
      seen = 1'b0; won_dm = 1'b0;
      if_req = 1'b1; if_addr = 32'h48;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
      for (int n = 0; n < 12 && !seen; n++) begin
        tick();
        if (if_ready || dm_ready) begin
          seen = 1'b1;
          won_dm = dm_ready;
        end
      end
      total_cnt++;
      if (!seen) $display("FAIL arb_timeout window %0d got no ready want ready", w);
      else if (won_dm !== want[w]) $display("FAIL arb_order window %0d got dm=%b want dm=%b", w, won_dm, want[w]);
      else pass_cnt++;
      if (seen && won_dm) begin
        total_cnt++; if (dm_rdata !== memval(32'h104)) $display("FAIL arb_dm_rdata got %h want %h", dm_rdata, memval(32'h104)); else pass_cnt++;
        last_dm = memval(32'h104);
      end else if (seen) begin
        total_cnt++; if (if_rdata !== memval(32'h48)) $display("FAIL arb_if_rdata got %h want %h", if_rdata, memval(32'h48)); else pass_cnt++;
        last_if = memval(32'h48);
      end
      if_req = 1'b0; dm_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_flush;
    if_req = 1'b1; if_addr = 32'h4C;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) begin if_flush = 1'b1; if_req = 1'b0; end
      if (c == 3) if_flush = 1'b0;
      total_cnt++; if (mem_en !== (c == 1)) $display("FAIL flush_mem_en c%0d got %b want %b", c, mem_en, c == 1); else pass_cnt++;
      total_cnt++; if (if_ready !== 1'b0) $display("FAIL flush_if_ready c%0d got %b want 0", c, if_ready); else pass_cnt++;
      if (c >= 4) begin
        total_cnt++; if (if_rdata !== last_if) $display("FAIL flush_if_rdata c%0d got %h want %h", c, if_rdata, last_if); else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++; if (dut.state !== IDLE) $display("FAIL flush_idle got %0d want IDLE", dut.state); else pass_cnt++;
      end
    end
  endtask

  task automatic test_store;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total_cnt++; if (mem_en !== (c == 1)) $display("FAIL store_mem_en c%0d got %b want %b", c, mem_en, c == 1); else pass_cnt++;
      total_cnt++; if (dm_ready !== (c == 4)) $display("FAIL store_dm_ready c%0d got %b want %b", c, dm_ready, c == 4); else pass_cnt++;
      if (c == 1) begin
        total_cnt++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF)
          $display("FAIL store_issue got we=%b %h/%h want we=1 00000200/deadbeef", mem_we, mem_addr, mem_wdata); else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++; if (dm_rdata !== last_dm) $display("FAIL store_dm_rdata got %h want %h", dm_rdata, last_dm); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h200 || mem_we !== 1'b1) $display("FAIL store_hold got %h/%b want 00000200/1", mem_addr, mem_we); else pass_cnt++;
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h108;
    tick();
    total_cnt++; if (mem_en !== 1'b1) $display("FAIL rstmid_mem_en got %b want 1", mem_en); else pass_cnt++;
    tick();
    reset = 1'b1;
    tick();
    total_cnt++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL rstmid_mem got %b%b %h/%h want 00 0/0", mem_en, mem_we, mem_addr, mem_wdata); else pass_cnt++;
    total_cnt++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || if_ready !== 1'b0 || dm_ready !== 1'b0)
      $display("FAIL rstmid_side got %h/%h %b%b want 0/0 00", if_rdata, dm_rdata, if_ready, dm_ready); else pass_cnt++;
    reset = 1'b0; dm_req = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      tick();
      total_cnt++; if (dm_ready !== 1'b0 || mem_en !== 1'b0) $display("FAIL rstmid_quiet c%0d got %b%b want 00", c, dm_ready, mem_en); else pass_cnt++;
    end
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total_cnt++; if (if_ready !== (c == 4)) $display("FAIL rstmid_fetch_ready c%0d got %b want %b", c, if_ready, c == 4); else pass_cnt++;
      if (c == 4) begin
        total_cnt++; if (if_rdata !== 32'h2001_0005) $display("FAIL rstmid_fetch_rdata got %h want 20010005", if_rdata); else pass_cnt++;
        if_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_fetch();
    test_priority();
    test_arb_windows();
    test_flush();
    test_store();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
